// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory port and loads IF/ID.
// Optional stall-cycle counter enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_pipeline,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc_plus4,
  output logic        IF_ID_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pc4, w_pc4_nxt;
  logic        r_req, w_req_nxt;
  logic        r_valid, w_valid_nxt;
  logic        w_ack;
  logic [31:0] w_addr_p4;

  assign w_ack     = imem_ack & r_req;
  assign w_addr_p4 = r_addr + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b1;
      r_hold  <= 32'h0;
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_hold  <= w_hold_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_req_nxt   = r_req;
    w_hold_nxt  = r_hold;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    case (r_state)
      FETCH: begin
        if (branch_taken) begin
          w_pc_nxt    = branch_target;
          w_valid_nxt = 1'b0;
          if (w_ack) begin
            w_addr_nxt = branch_target;
            w_req_nxt  = 1'b1;
          end else begin
            // Outstanding request must still complete; its data is discarded.
            w_state_nxt = DRAIN;
          end
        end else if (w_ack && !stall_pipeline) begin
          w_instr_nxt = imem_rdata;
          w_pc4_nxt   = w_addr_p4;
          w_valid_nxt = 1'b1;
          w_pc_nxt    = w_addr_p4;
          w_addr_nxt  = w_addr_p4;
        end else if (w_ack) begin
          w_hold_nxt  = imem_rdata;
          w_pc_nxt    = w_addr_p4;
          w_req_nxt   = 1'b0;
          w_state_nxt = HOLD;
        end else if (!stall_pipeline) begin
          w_valid_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          w_pc_nxt    = branch_target;
          w_valid_nxt = 1'b0;
          w_addr_nxt  = branch_target;
          w_req_nxt   = 1'b1;
          w_state_nxt = FETCH;
        end else if (!stall_pipeline) begin
          w_instr_nxt = r_hold;
          w_pc4_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          w_addr_nxt  = r_pc;
          w_req_nxt   = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          w_pc_nxt    = branch_target;
          w_valid_nxt = 1'b0;
        end
        if (w_ack) begin
          w_addr_nxt  = branch_taken ? branch_target : r_pc;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  assign imem_req       = r_req;
  assign imem_addr      = r_addr;
  assign IF_ID_instr    = r_instr;
  assign IF_ID_pc_plus4 = r_pc4;
  assign IF_ID_valid    = r_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'h0;
    end else if (stall_pipeline && !branch_taken && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed scoreboard bench for if_fetch_stage: accepted fetches are queued and checked when IF/ID loads.
module tb_if_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_pipeline;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc_plus4;
  logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_pipeline (stall_pipeline),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .IF_ID_instr    (IF_ID_instr),
    .IF_ID_pc_plus4 (IF_ID_pc_plus4),
    .IF_ID_valid    (IF_ID_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t, input logic a);
    stall_pipeline = s;
    branch_taken   = b;
    branch_target  = t;
    imem_ack       = a;
    imem_rdata     = a ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    cyc();
    cyc();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, RPC}) begin
      n_fail++;
      $display("FAIL reset_req_addr: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RPC);
    end
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_ifid: got v=%b instr=%h pc4=%h want all zero", IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea;
    ent_t e;
    for (int i = 0; i < 3; i++) begin
      ea = RPC + 32'(4 * i);
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, ea}) begin
        n_fail++;
        $display("FAIL b2b_addr[%0d]: got req=%b addr=%h want req=1 addr=%h", i, imem_req, imem_addr, ea);
      end
      drive(0, 0, 32'h0, 1);
      sb.push_back({mem_word(ea), ea + 32'd4});
      cyc();
      e = sb.pop_front();
      n_checks++;
      if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, e}) begin
        n_fail++;
        $display("FAIL b2b_load[%0d]: got v=%b instr=%h pc4=%h want v=1 instr=%h pc4=%h",
                 i, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, e.instr, e.pc4);
      end
    end
  endtask

  task automatic test_ack_delay();
    ent_t e;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 32'h0, 0);
      cyc();
      n_checks++;
      if ({imem_req, imem_addr, IF_ID_valid} !== {1'b1, 32'h10C, 1'b0}) begin
        n_fail++;
        $display("FAIL delay_wait[%0d]: got req=%b addr=%h v=%b want req=1 addr=0000010c v=0",
                 i, imem_req, imem_addr, IF_ID_valid);
      end
    end
    drive(0, 0, 32'h0, 1);
    sb.push_back({mem_word(32'h10C), 32'h110});
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, e, 32'h110}) begin
      n_fail++;
      $display("FAIL delay_load: got v=%b instr=%h pc4=%h addr=%h want instr=%h pc4=%h addr=00000110",
               IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr, e.instr, e.pc4);
    end
  endtask

  task automatic test_stall_hold();
    ent_t e;
    drive(1, 0, 32'h0, 1);
    sb.push_back({mem_word(32'h110), 32'h114});
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if ({imem_req, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b0, 1'b1, mem_word(32'h10C), 32'h110}) begin
        n_fail++;
        $display("FAIL hold_frozen[%0d]: got req=%b v=%b instr=%h pc4=%h want req=0 v=1 instr=%h pc4=00000110",
                 i, imem_req, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, mem_word(32'h10C));
      end
      drive(1, 0, 32'h0, 0);
    end
    drive(0, 0, 32'h0, 0);
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL hold_release: got v=%b instr=%h pc4=%h want instr=%h pc4=%h",
               IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, e.instr, e.pc4);
    end
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h114}) begin
      n_fail++;
      $display("FAIL hold_next_req: got req=%b addr=%h want req=1 addr=00000114", imem_req, imem_addr);
    end
    drive(0, 0, 32'h0, 1);
    sb.push_back({mem_word(32'h114), 32'h118});
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL hold_after: got v=%b instr=%h pc4=%h want instr=%h pc4=%h",
               IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, e.instr, e.pc4);
    end
  endtask

  task automatic test_branch_drain();
    ent_t e;
    drive(0, 1, 32'h200, 0);
    cyc();
    n_checks++;
    if ({imem_req, imem_addr, IF_ID_valid} !== {1'b1, 32'h118, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_enter: got req=%b addr=%h v=%b want req=1 addr=00000118 v=0", imem_req, imem_addr, IF_ID_valid);
    end
    drive(0, 1, 32'h280, 0);
    cyc();
    n_checks++;
    if ({imem_req, imem_addr, IF_ID_valid} !== {1'b1, 32'h118, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_rebranch: got req=%b addr=%h v=%b want req=1 addr=00000118 v=0", imem_req, imem_addr, IF_ID_valid);
    end
    drive(0, 0, 32'h0, 1);
    cyc();
    n_checks++;
    if ({imem_req, imem_addr, IF_ID_valid} !== {1'b1, 32'h280, 1'b0}) begin
      n_fail++;
      $display("FAIL drain_discard: got req=%b addr=%h v=%b want req=1 addr=00000280 v=0", imem_req, imem_addr, IF_ID_valid);
    end
    drive(0, 0, 32'h0, 1);
    sb.push_back({mem_word(32'h280), 32'h284});
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL drain_target_load: got v=%b instr=%h pc4=%h want instr=%h pc4=%h",
               IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, e.instr, e.pc4);
    end
  endtask

  task automatic test_branch_hold();
    ent_t e;
    drive(1, 0, 32'h0, 1);
    cyc();
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL bhold_enter: got req=%b want req=0", imem_req);
    end
    drive(1, 1, 32'h300, 0);
    cyc();
    n_checks++;
    if ({imem_req, imem_addr, IF_ID_valid} !== {1'b1, 32'h300, 1'b0}) begin
      n_fail++;
      $display("FAIL bhold_redirect: got req=%b addr=%h v=%b want req=1 addr=00000300 v=0", imem_req, imem_addr, IF_ID_valid);
    end
    drive(0, 0, 32'h0, 1);
    sb.push_back({mem_word(32'h300), 32'h304});
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL bhold_target_load: got v=%b instr=%h pc4=%h want instr=%h pc4=%h",
               IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, e.instr, e.pc4);
    end
  endtask

  task automatic test_branch_ack_wrap();
    ent_t e;
    drive(0, 1, 32'hFFFF_FFFC, 1);
    cyc();
    n_checks++;
    if ({imem_req, imem_addr, IF_ID_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
      n_fail++;
      $display("FAIL back_redirect: got req=%b addr=%h v=%b want req=1 addr=fffffffc v=0", imem_req, imem_addr, IF_ID_valid);
    end
    drive(0, 0, 32'h0, 1);
    sb.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr} !== {1'b1, e, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_load: got v=%b instr=%h pc4=%h addr=%h want instr=%h pc4=%h addr=00000000",
               IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, imem_addr, e.instr, e.pc4);
    end
  endtask

  task automatic test_stall_noack();
    ent_t e;
    drive(1, 0, 32'h0, 0);
    cyc();
    n_checks++;
    if ({imem_req, imem_addr, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !==
        {1'b1, 32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 32'h0}) begin
      n_fail++;
      $display("FAIL stall_noack_keep: got req=%b addr=%h v=%b instr=%h pc4=%h want req=1 addr=0 v=1 instr=%h pc4=0",
               imem_req, imem_addr, IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, mem_word(32'hFFFF_FFFC));
    end
    drive(0, 0, 32'h0, 1);
    sb.push_back({mem_word(32'h0), 32'h4});
    cyc();
    e = sb.pop_front();
    n_checks++;
    if ({IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4} !== {1'b1, e}) begin
      n_fail++;
      $display("FAIL stall_noack_load: got v=%b instr=%h pc4=%h want instr=%h pc4=%h",
               IF_ID_valid, IF_ID_instr, IF_ID_pc_plus4, e.instr, e.pc4);
    end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_cnt();
    drive(0, 0, 32'h0, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n_checks++;
    if (stall_cycles !== 32'h0) begin
      n_fail++;
      $display("FAIL perf_reset: got %0d want 0", stall_cycles);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, (i == 2), 32'h500, 0);
      cyc();
    end
    n_checks++;
    if (stall_cycles !== 32'd4) begin
      n_fail++;
      $display("FAIL perf_count: got %0d want 4", stall_cycles);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 32'h0, 0);
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_ack_delay();
    test_stall_hold();
    test_branch_drain();
    test_branch_hold();
    test_branch_ack_wrap();
    test_stall_noack();
`ifdef IF_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
